wbicape_reboot_ctrl: RTL and testbench

//  Wishbone master sequencer that drives the ICAPE2 slave port for two canned jobs.

---
 rtl/wbicape_reboot_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_wbicape_reboot_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbicape_reboot_ctrl.sv
// rtl/wbicape_reboot_ctrl.sv - Wishbone sequencer for ICAPE2 warm-boot and boot-status jobs
module wbicape_reboot_ctrl #(
    parameter int LGTIMEOUT = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_reboot,
    input  logic [31:0] i_boot_addr,
    input  logic        i_status_rd,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_status,
    output logic        o_status_valid,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic [31:0] i_wb_data
);

    localparam logic [4:0]  ADDR_CMD     = 5'h04;
    localparam logic [4:0]  ADDR_WBSTAR  = 5'h10;
    localparam logic [4:0]  ADDR_BOOTSTS = 5'h16;
    localparam logic [31:0] CMD_IPROG    = 32'h0000_000f;

    // The abort fires on the edge where the counter would step onto 2^LGTIMEOUT,
    // so the bus is held for exactly 2^LGTIMEOUT cycles.
    localparam logic [LGTIMEOUT:0] TIMER_LAST = {1'b0, {LGTIMEOUT{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSTAR_REQ,
        S_WSTAR_WAIT,
        S_GAP,
        S_CMD_REQ,
        S_CMD_WAIT,
        S_RD_REQ,
        S_RD_WAIT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [31:0]          boot_addr_q;
    logic [LGTIMEOUT:0]   timer_q;

    logic                 bus_active;
    logic                 timer_expired;
    logic                 timer_clear;
    logic                 job_accept;
    logic                 job_done;
    logic                 txn_ack;
    logic                 status_capture;
    logic                 timeout_abort;

    assign bus_active    = (state_q == S_WSTAR_REQ) || (state_q == S_WSTAR_WAIT) ||
                           (state_q == S_CMD_REQ)   || (state_q == S_CMD_WAIT)   ||
                           (state_q == S_RD_REQ)    || (state_q == S_RD_WAIT);
    assign timer_expired = bus_active && (timer_q == TIMER_LAST);

    // Next-state logic and per-cycle event flags for the job sequencer
    always_comb begin
        state_d        = state_q;
        timer_clear    = 1'b0;
        job_accept     = 1'b0;
        job_done       = 1'b0;
        txn_ack        = 1'b0;
        status_capture = 1'b0;
        timeout_abort  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Reboot has priority; a simultaneous status request is dropped.
                if (i_reboot) begin
                    state_d     = S_WSTAR_REQ;
                    job_accept  = 1'b1;
                    timer_clear = 1'b1;
                end else if (i_status_rd) begin
                    state_d     = S_RD_REQ;
                    job_accept  = 1'b1;
                    timer_clear = 1'b1;
                end
            end
            S_WSTAR_REQ: begin
                if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        state_d = S_GAP;
                        txn_ack = 1'b1;
                    end else begin
                        state_d = S_WSTAR_WAIT;
                    end
                end
            end
            S_WSTAR_WAIT: begin
                if (i_wb_ack) begin
                    state_d = S_GAP;
                    txn_ack = 1'b1;
                end
            end
            S_GAP: begin
                state_d     = S_CMD_REQ;
                timer_clear = 1'b1;
            end
            S_CMD_REQ: begin
                if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        state_d  = S_IDLE;
                        txn_ack  = 1'b1;
                        job_done = 1'b1;
                    end else begin
                        state_d = S_CMD_WAIT;
                    end
                end
            end
            S_CMD_WAIT: begin
                if (i_wb_ack) begin
                    state_d  = S_IDLE;
                    txn_ack  = 1'b1;
                    job_done = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (!i_wb_stall) begin
                    if (i_wb_ack) begin
                        state_d        = S_IDLE;
                        txn_ack        = 1'b1;
                        job_done       = 1'b1;
                        status_capture = 1'b1;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                if (i_wb_ack) begin
                    state_d        = S_IDLE;
                    txn_ack        = 1'b1;
                    job_done       = 1'b1;
                    status_capture = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An ack landing on the last allowed cycle still completes the transaction;
        // otherwise the whole job is abandoned, so no IPROG follows a failed WBSTAR.
        if (timer_expired && !txn_ack) begin
            state_d        = S_IDLE;
            timeout_abort  = 1'b1;
            job_done       = 1'b0;
            status_capture = 1'b0;
            timer_clear    = 1'b0;
        end
    end

    // Bus and status outputs decoded purely from registered state
    always_comb begin
        o_busy    = (state_q != S_IDLE);
        o_wb_cyc  = bus_active;
        o_wb_stb  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_addr = 5'h00;
        o_wb_data = 32'h0000_0000;
        case (state_q)
            S_WSTAR_REQ, S_WSTAR_WAIT: begin
                o_wb_stb  = (state_q == S_WSTAR_REQ);
                o_wb_we   = 1'b1;
                o_wb_addr = ADDR_WBSTAR;
                o_wb_data = boot_addr_q;
            end
            S_CMD_REQ, S_CMD_WAIT: begin
                o_wb_stb  = (state_q == S_CMD_REQ);
                o_wb_we   = 1'b1;
                o_wb_addr = ADDR_CMD;
                o_wb_data = CMD_IPROG;
            end
            S_RD_REQ, S_RD_WAIT: begin
                o_wb_stb  = (state_q == S_RD_REQ);
                o_wb_addr = ADDR_BOOTSTS;
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-transaction ack timeout counter, restarted on every request entry
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer_q <= '0;
        end else if (timer_clear) begin
            timer_q <= '0;
        end else if (bus_active) begin
            timer_q <= timer_q + 1'b1;
        end
    end

    // Job results: boot address latch, done pulse, sticky error, captured BOOTSTS
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            boot_addr_q    <= 32'h0000_0000;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_status       <= 32'h0000_0000;
            o_status_valid <= 1'b0;
        end else begin
            o_done <= job_done;
            if (job_accept) begin
                boot_addr_q    <= i_boot_addr;
                o_err          <= 1'b0;
                o_status_valid <= 1'b0;
            end
            if (timeout_abort) begin
                o_err <= 1'b1;
            end
            if (status_capture) begin
                o_status       <= i_wb_data;
                o_status_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wbicape_reboot_ctrl.sv
// tb/tb_wbicape_reboot_ctrl.sv - Randomized self-checking bench for wbicape_reboot_ctrl
module tb_wbicape_reboot_ctrl;

    localparam int LG        = 5;
    localparam int TO_CYCLES = 1 << LG;

    logic        clk = 1'b0;
    logic        rst;
    logic        reb;
    logic        st;
    logic [31:0] baddr;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] status;
    logic        status_valid;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_wdata;
    logic        ack;
    logic        stall;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    wbicape_reboot_ctrl #(.LGTIMEOUT(LG)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_reboot       (reb),
        .i_boot_addr    (baddr),
        .i_status_rd    (st),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err),
        .o_status       (status),
        .o_status_valid (status_valid),
        .o_wb_cyc       (wb_cyc),
        .o_wb_stb       (wb_stb),
        .o_wb_we        (wb_we),
        .o_wb_addr      (wb_addr),
        .o_wb_data      (wb_wdata),
        .i_wb_ack       (ack),
        .i_wb_stall     (stall),
        .i_wb_data      (rd_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // slave behaviour per transaction index: stall cycles, ack delay after accept (-1 = never)
    int stall_cfg [2];
    int dly_cfg   [2];

    // observations of the last job
    logic [37:0] txn_log [$];
    logic [37:0] exp_txn [$];
    int done_at;
    int done_count;
    int cyc_cycles;
    int stab_err;

    // reference state
    logic [31:0] model_status = 32'h0;
    logic        model_valid  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int txn_len(input int i);
        return stall_cfg[i] + 1 + dly_cfg[i];
    endfunction

    // Expected o_done cycle, counted in edges after the request is sampled
    function automatic int exp_done_cycle(input bit is_reboot);
        if (is_reboot) return 1 + txn_len(0) + 1 + txn_len(1);
        return 1 + txn_len(0);
    endfunction

    task automatic build_expect(input bit is_reboot, input logic [31:0] addr);
        exp_txn.delete();
        if (is_reboot) begin
            exp_txn.push_back({1'b1, 5'h10, addr});
            exp_txn.push_back({1'b1, 5'h04, 32'h0000_000f});
        end else begin
            exp_txn.push_back({1'b0, 5'h16, 32'h0});
        end
    endtask

    task automatic check_txns(input string tag);
        check({tag, "_ntxn"}, 64'(txn_log.size()), 64'(exp_txn.size()));
        for (int i = 0; i < exp_txn.size() && i < txn_log.size(); i++)
            check({tag, "_txn"}, 64'(txn_log[i]), 64'(exp_txn[i]));
    endtask

    // Runs one job, acting as the wishbone slave; inputs change at the falling edge.
    task automatic run_job(input bit do_reb, input bit do_st, input logic [31:0] addr,
                           input bit poke_gap, input bit rst_cmd_wait, input int budget);
        int cycle = 0;
        int txn = 0;
        int stall_left = -1;
        int ack_wait = -1;
        logic [37:0] prev = '0;
        bit have_prev = 1'b0;
        txn_log.delete();
        done_at = -1;
        done_count = 0;
        cyc_cycles = 0;
        stab_err = 0;
        @(negedge clk);
        reb = do_reb;
        st = do_st;
        baddr = addr;
        ack = 1'b0;
        stall = 1'b0;
        while (1) begin
            @(posedge clk);
            @(negedge clk);
            cycle++;
            reb = 1'b0;
            st = 1'b0;
            ack = 1'b0;
            stall = 1'b0;
            if (done) begin
                done_count++;
                if (done_at < 0) done_at = cycle;
            end
            if (wb_cyc) cyc_cycles++;
            if (wb_stb) begin
                if (stall_left < 0) stall_left = (txn < 2) ? stall_cfg[txn] : 0;
                else if (have_prev && prev !== {wb_we, wb_addr, wb_wdata}) stab_err++;
                prev = {wb_we, wb_addr, wb_wdata};
                have_prev = 1'b1;
                if (stall_left > 0) begin
                    stall = 1'b1;
                    stall_left--;
                end else begin
                    txn_log.push_back(prev);
                    ack_wait = (txn < 2) ? dly_cfg[txn] : 1;
                    stall_left = -1;
                    have_prev = 1'b0;
                    txn++;
                    if (ack_wait == 0) begin
                        ack = 1'b1;
                        ack_wait = -1;
                    end
                end
            end else if (ack_wait > 0) begin
                ack_wait--;
                if (ack_wait == 0) begin
                    ack = 1'b1;
                    ack_wait = -1;
                end
            end
            if (poke_gap && busy && !wb_cyc) st = 1'b1;
            if (rst_cmd_wait && txn == 2 && wb_cyc && !wb_stb && !ack) begin
                #1 rst = 1'b1;
                #1;
                check("rst_async_cyc", 64'(wb_cyc), 64'd0);
                check("rst_async_stb", 64'(wb_stb), 64'd0);
                check("rst_async_busy", 64'(busy), 64'd0);
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (!busy) break;
            if (cycle >= budget) begin
                check("job_budget_busy", 64'(busy), 64'd0);
                break;
            end
        end
        ack = 1'b0;
        stall = 1'b0;
    endtask

    // Idle for n cycles and count any bus activity
    task automatic idle_cycles(input int n, output int active);
        active = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (wb_cyc || busy) active++;
        end
    endtask

    task automatic check_job_ok(input string tag, input bit is_reboot, input logic [31:0] addr);
        build_expect(is_reboot, addr);
        check_txns(tag);
        check({tag, "_done_at"}, 64'(done_at), 64'(exp_done_cycle(is_reboot)));
        check({tag, "_done_n"}, 64'(done_count), 64'd1);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_stable"}, 64'(stab_err), 64'd0);
        if (!is_reboot) begin
            model_status = rd_data;
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        check({tag, "_status"}, 64'(status), 64'(model_status));
        check({tag, "_svalid"}, 64'(status_valid), 64'(model_valid));
    endtask

    initial begin
        int active;
        logic [31:0] a;
        bit kind;
        rst = 1'b1;
        reb = 1'b0;
        st = 1'b0;
        baddr = 32'h0;
        ack = 1'b0;
        stall = 1'b0;
        rd_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({busy, done, err, status_valid, wb_cyc, wb_stb, wb_we, wb_addr}), 64'd0);
        check("reset_status", 64'(status), 64'd0);
        check("reset_wdata", 64'(wb_wdata), 64'd0);
        rst = 1'b0;

        // zero-wait reboot
        stall_cfg = '{0, 0};
        dly_cfg = '{1, 1};
        run_job(1'b1, 1'b0, 32'h0040_0000, 1'b0, 1'b0, 200);
        check_job_ok("zw_reboot", 1'b1, 32'h0040_0000);
        check("zw_reboot_cyc_cycles", 64'(cyc_cycles), 64'd4);

        // slow ICAPE2-like slave
        stall_cfg = '{7, 7};
        dly_cfg = '{20, 20};
        a = $urandom;
        run_job(1'b1, 1'b0, a, 1'b0, 1'b0, 200);
        check_job_ok("slow_reboot", 1'b1, a);

        // status read
        stall_cfg = '{0, 0};
        dly_cfg = '{1, 1};
        rd_data = 32'h0000_0101;
        run_job(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 200);
        check_job_ok("status", 1'b0, 32'h0);

        // WBSTAR write never acked
        stall_cfg = '{0, 0};
        dly_cfg = '{-1, 1};
        run_job(1'b1, 1'b0, 32'h0123_4560, 1'b0, 1'b0, 200);
        build_expect(1'b1, 32'h0123_4560);
        exp_txn.pop_back();
        check_txns("timeout");
        check("timeout_cyc_cycles", 64'(cyc_cycles), 64'(TO_CYCLES));
        check("timeout_err", 64'(err), 64'd1);
        check("timeout_no_done", 64'(done_count), 64'd0);
        check("timeout_svalid", 64'(status_valid), 64'd0);
        idle_cycles(5, active);
        check("timeout_quiet", 64'(active), 64'd0);
        check("timeout_err_sticky", 64'(err), 64'd1);
        dly_cfg = '{1, 1};
        rd_data = $urandom;
        run_job(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 200);
        check_job_ok("after_timeout", 1'b0, 32'h0);

        // simultaneous requests, plus a status request during the gap
        a = $urandom;
        run_job(1'b1, 1'b1, a, 1'b1, 1'b0, 200);
        check_job_ok("both_req", 1'b1, a);
        idle_cycles(4, active);
        check("both_req_not_queued", 64'(active), 64'd0);

        // reset while waiting for the IPROG ack, then a normal status job
        stall_cfg = '{0, 0};
        dly_cfg = '{1, 10};
        run_job(1'b1, 1'b0, $urandom, 1'b0, 1'b1, 200);
        model_status = 32'h0;
        model_valid = 1'b0;
        check("post_reset_err", 64'(err), 64'd0);
        check("post_reset_status", 64'(status), 64'd0);
        dly_cfg = '{1, 1};
        rd_data = $urandom;
        run_job(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 200);
        check_job_ok("post_reset_job", 1'b0, 32'h0);

        // randomized jobs
        for (int i = 0; i < 12; i++) begin
            kind = 1'($urandom_range(0, 1));
            stall_cfg[0] = $urandom_range(0, 7);
            stall_cfg[1] = $urandom_range(0, 7);
            dly_cfg[0] = $urandom_range(0, 12);
            dly_cfg[1] = $urandom_range(0, 12);
            rd_data = $urandom;
            a = $urandom;
            run_job(kind, !kind, a, 1'b0, 1'b0, 200);
            check_job_ok(kind ? "rand_reboot" : "rand_status", kind, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
